bus_master_port: RTL and testbench
==================================

// Module: bus_master_port
// PURPOSE
//  Master-side serial bus interface, directly upstream of the arbiter.
//  Takes one parallel host transaction (read/write, slave id, address, write data).
//  Requests the bus, waits for grant, then shifts out slave select, address and write data serially.
//  Collects the write ack or the serial read data, then releases the bus.
//  One instance sits per master (m1, m2); its m_request/m_grant/slave_select connect to the arbiter.
// PARAMETERS
//  SLAVE_SEL_W  3   slave-select bits shifted on slave_select, LSB first
//  ADDR_W       12  address bits shifted on m_sout
//  DATA_W       8   data width (write and read)
//  TIMEOUT      15  max cycles in WAIT for s_ready before abort
// PORTS
//  clk           in   1             single clock, all logic on rising edge
//  reset         in   1             synchronous, active-high
//  h_start       in   1             host starts a transaction; accepted only when h_ready=1
//  h_rw          in   1             1=write, 0=read
//  h_slave       in   SLAVE_SEL_W   slave-select pattern
//  h_addr        in   ADDR_W        target address
//  h_wdata       in   DATA_W        write data
//  h_ready       out  1             port idle, can accept h_start
//  h_done        out  1             one-cycle pulse, transaction finished
//  h_error       out  1             valid with h_done: 1 = timeout or grant lost
//  h_rdata       out  DATA_W        read data, valid with h_done on a successful read
//  m_request     out  1             bus request to arbiter
//  m_grant       in   1             grant from arbiter
//  slave_select  out  1             serial slave-select line to arbiter
//  m_valid       out  1             high while m_sout carries address/data bits
//  m_rw          out  1             latched h_rw, driven while m_request=1
//  m_sout        out  1             serial address then write data, LSB first
//  m_sin         in   1             serial read data from slave, LSB first
//  s_ready       in   1             slave ack (write) / read-data-follows (read)
// BEHAVIOUR
//  Reset: state=IDLE; h_ready=1; all other outputs 0; h_rdata=0; counters 0.
//  Reset takes priority in any state, including mid-transfer.
//    Outputs are 0 the cycle after reset is sampled.
//    No h_done is issued for the aborted transaction.
//  IDLE: h_start&h_ready -> latch h_rw/h_slave/h_addr/h_wdata -> REQ. h_ready=0 from next cycle.
//  REQ: m_request=1. Stays until m_grant sampled 1, then -> SEL. No request timeout.
//  SEL: SLAVE_SEL_W cycles. slave_select=h_slave[i], i=0..SLAVE_SEL_W-1.
//    First bit is driven in the cycle after the grant was sampled.
//  ADDR: ADDR_W cycles. m_valid=1, m_sout=addr[i]. Write -> WDATA; read -> WAIT.
//  WDATA: DATA_W cycles. m_valid=1, m_sout=wdata[i]. -> WAIT.
//  WAIT: m_valid=0; timeout counter counts cycles.
//    s_ready=1: write -> DONE(ok); read -> RDATA.
//    TIMEOUT cycles without s_ready -> DONE(error).
//    s_ready and the final timeout cycle together: s_ready wins.
//  RDATA: DATA_W cycles. Shift m_sin into h_rdata[i], LSB first, one bit per cycle. -> DONE.
//  DONE: one cycle. m_request=0, h_done=1, h_error as set. -> IDLE, h_ready=1 next cycle.
//  m_request stays 1 from REQ through RDATA; it drops in DONE so the arbiter can regrant.
//  Grant lost (m_grant=0) in SEL/ADDR/WDATA/WAIT/RDATA -> DONE with h_error=1.
//  On error, h_rdata holds its previous value.
//  slave_select=0 outside SEL. m_sout=0 when m_valid=0.
//  h_start while h_ready=0 is ignored (no queueing).
//  Bit counter is wide enough for max(SLAVE_SEL_W, ADDR_W, DATA_W). It reloads to 0 on every state change.
//  Min write latency from grant sampled to h_done: SLAVE_SEL_W+ADDR_W+DATA_W+2 cycles (s_ready on first WAIT cycle).
// STRUCTURE
//  Shared package/header bus_defs: state encodings (IDLE,REQ,SEL,ADDR,WDATA,WAIT,RDATA,DONE),
//    RW_WRITE=1 / RW_READ=0, default widths shared with the arbiter and slave ports.
//  One natural sub-module: bus_shift_reg (parallel-load/serial-out and serial-in/parallel-out, LSB first).
//    Used for the address/data TX path and the read-data RX path.
//  FSM, bit counter and timeout counter stay in this module.
// TESTING
//  1 Write: h_slave=3'b101, h_addr=12'h0A5, h_wdata=8'h3C, grant 2 cycles after m_request, s_ready on first WAIT cycle
//    -> slave_select bits 1,0,1; m_sout = A5 0 then 3C, LSB first; h_done with h_error=0.
//  2 Read: h_addr=12'h123; s_ready after 4 WAIT cycles, then m_sin=8'h96 LSB first
//    -> h_rdata=8'h96 with h_done, h_error=0.
//  3 Timeout: write, s_ready never asserted -> h_done+h_error exactly TIMEOUT=15 cycles after WAIT entry; m_request=0 in DONE.
//  4 Grant loss: drop m_grant in the 5th ADDR cycle -> DONE next cycle, h_error=1, m_valid=0, then IDLE.
//  5 Contention: two ports on the arbiter, both h_start together -> transactions serialize; each slave_select burst starts one cycle after its own grant.
//  6 Reset mid-RDATA -> next cycle all outputs 0, h_ready=1, no h_done; a new h_start completes normally.

Source files
------------

// File: rtl/bus_master_port_pkg.sv
// Shared bus definitions: FSM state encoding, read/write codes and the
// default widths used by the master port, the arbiter and the slave ports.
package bus_master_port_pkg;

   localparam int unsigned SLAVE_SEL_W_DEF = 3;
   localparam int unsigned ADDR_W_DEF      = 12;
   localparam int unsigned DATA_W_DEF      = 8;
   localparam int unsigned TIMEOUT_DEF     = 15;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_SEL   = 3'd2,
      ST_ADDR  = 3'd3,
      ST_WDATA = 3'd4,
      ST_WAIT  = 3'd5,
      ST_RDATA = 3'd6,
      ST_DONE  = 3'd7
   } state_e;

   // Largest of three widths; sizes the shared bit counter.
   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// LSB-first shift register: parallel load / serial out (q_o[0]) and
// serial in (sin_i enters at the MSB) / parallel out.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   load_i         load load_data_i (wins over shift_i)
//   shift_i        shift one position towards bit 0, sin_i into MSB
//   q_o            current register contents
//   nxt_c_o        value the register takes at the next edge
module bus_shift_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   input  logic         shift_i,
   input  logic         sin_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] nxt_c_o
);

   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_data_i;
      end else if (shift_i) begin
         q_d = W'({sin_i, q_q} >> 1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o     = q_q;
   assign nxt_c_o = q_d;

endmodule

// File: rtl/bus_master_port.sv
// Master-side serial bus port. Accepts one host transaction, requests the
// bus, then serialises slave select, address and write data (LSB first),
// collects the write ack or serial read data and releases the bus.
// Ports:
//   host side : h_start/h_rw/h_slave/h_addr/h_wdata in; h_ready/h_done/h_error/h_rdata out
//   arbiter   : m_request out, m_grant in, slave_select out
//   bus       : m_valid/m_rw/m_sout out; m_sin/s_ready in
// All outputs are registered; their next values are decoded from the next state.
module bus_master_port
   import bus_master_port_pkg::*;
#(
   parameter int unsigned SLAVE_SEL_W = SLAVE_SEL_W_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   h_start,
   input  logic                   h_rw,
   input  logic [SLAVE_SEL_W-1:0] h_slave,
   input  logic [ADDR_W-1:0]      h_addr,
   input  logic [DATA_W-1:0]      h_wdata,
   output logic                   h_ready,
   output logic                   h_done,
   output logic                   h_error,
   output logic [DATA_W-1:0]      h_rdata,
   output logic                   m_request,
   input  logic                   m_grant,
   output logic                   slave_select,
   output logic                   m_valid,
   output logic                   m_rw,
   output logic                   m_sout,
   input  logic                   m_sin,
   input  logic                   s_ready
);

   localparam int unsigned BIT_MAX = max3(SLAVE_SEL_W, ADDR_W, DATA_W);
   localparam int unsigned CNT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
   localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned TX_W    = ADDR_W + DATA_W;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              rw_q, rw_d;

   logic              h_ready_q, h_ready_d;
   logic              h_done_q, h_done_d;
   logic              h_error_q, h_error_d;
   logic [DATA_W-1:0] h_rdata_q, h_rdata_d;
   logic              m_request_q, m_request_d;
   logic              slave_select_q, slave_select_d;
   logic              m_valid_q, m_valid_d;
   logic              m_rw_q, m_rw_d;
   logic              m_sout_q, m_sout_d;

   logic              accept_c, err_c, sel_shift_c, rx_shift_c;

   logic [SLAVE_SEL_W-1:0] sel_q, sel_nxt;
   logic [TX_W-1:0]        tx_q, tx_nxt;
   logic [DATA_W-1:0]      rx_q, rx_nxt;
   logic                   unused_ok;

   // Slave-select pattern, shifted out during SEL.
   bus_shift_reg #(.W(SLAVE_SEL_W)) u_sel_sr (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept_c),
      .load_data_i(h_slave),
      .shift_i    (sel_shift_c),
      .sin_i      (1'b0),
      .q_o        (sel_q),
      .nxt_c_o    (sel_nxt)
   );

   // Address followed by write data; a read simply never shifts the data half.
   bus_shift_reg #(.W(TX_W)) u_tx_sr (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept_c),
      .load_data_i({h_wdata, h_addr}),
      .shift_i    (m_valid_d),
      .sin_i      (1'b0),
      .q_o        (tx_q),
      .nxt_c_o    (tx_nxt)
   );

   // Read data capture; committed to h_rdata only on a clean finish.
   bus_shift_reg #(.W(DATA_W)) u_rx_sr (
      .clk        (clk),
      .reset      (reset),
      .load_i     (1'b0),
      .load_data_i('0),
      .shift_i    (rx_shift_c),
      .sin_i      (m_sin),
      .q_o        (rx_q),
      .nxt_c_o    (rx_nxt)
   );

   assign unused_ok = ^{sel_q, sel_nxt, tx_q, tx_nxt, rx_q};

   // Next state; grant loss takes priority over every other exit.
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      err_c    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (h_start && h_ready_q) begin
               accept_c = 1'b1;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (m_grant) state_d = ST_SEL;
         end
         ST_SEL: begin
            if (!m_grant) begin
               state_d = ST_DONE;
               err_c   = 1'b1;
            end else if (cnt_q == CNT_W'(SLAVE_SEL_W - 1)) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (!m_grant) begin
               state_d = ST_DONE;
               err_c   = 1'b1;
            end else if (cnt_q == CNT_W'(ADDR_W - 1)) begin
               state_d = (rw_q == RW_WRITE) ? ST_WDATA : ST_WAIT;
            end
         end
         ST_WDATA: begin
            if (!m_grant) begin
               state_d = ST_DONE;
               err_c   = 1'b1;
            end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // s_ready beats a timeout falling in the same cycle.
            if (!m_grant) begin
               state_d = ST_DONE;
               err_c   = 1'b1;
            end else if (s_ready) begin
               state_d = (rw_q == RW_WRITE) ? ST_DONE : ST_RDATA;
            end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
               state_d = ST_DONE;
               err_c   = 1'b1;
            end
         end
         ST_RDATA: begin
            if (!m_grant) begin
               state_d = ST_DONE;
               err_c   = 1'b1;
            end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Counters and registered outputs, decoded from the next state.
   always_comb begin
      cnt_d          = '0;
      tcnt_d         = '0;
      rw_d           = accept_c ? h_rw : rw_q;
      sel_shift_c    = (state_d == ST_SEL);
      rx_shift_c     = (state_q == ST_RDATA);
      h_ready_d      = (state_d == ST_IDLE);
      h_done_d       = (state_d == ST_DONE);
      h_error_d      = (state_d == ST_DONE) && err_c;
      h_rdata_d      = h_rdata_q;
      m_request_d    = state_d inside {ST_REQ, ST_SEL, ST_ADDR, ST_WDATA, ST_WAIT, ST_RDATA};
      m_valid_d      = state_d inside {ST_ADDR, ST_WDATA};
      m_rw_d         = m_request_d ? rw_d : 1'b0;
      slave_select_d = sel_shift_c ? sel_q[0] : 1'b0;
      m_sout_d       = m_valid_d ? tx_q[0] : 1'b0;

      if (state_d == state_q && state_q inside {ST_SEL, ST_ADDR, ST_WDATA, ST_RDATA}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_d == ST_WAIT && state_q == ST_WAIT) begin
         tcnt_d = tcnt_q + TO_W'(1);
      end
      if (state_q == ST_RDATA && state_d == ST_DONE && !err_c) begin
         h_rdata_d = rx_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         tcnt_q         <= '0;
         rw_q           <= 1'b0;
         h_ready_q      <= 1'b1;
         h_done_q       <= 1'b0;
         h_error_q      <= 1'b0;
         h_rdata_q      <= '0;
         m_request_q    <= 1'b0;
         slave_select_q <= 1'b0;
         m_valid_q      <= 1'b0;
         m_rw_q         <= 1'b0;
         m_sout_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tcnt_q         <= tcnt_d;
         rw_q           <= rw_d;
         h_ready_q      <= h_ready_d;
         h_done_q       <= h_done_d;
         h_error_q      <= h_error_d;
         h_rdata_q      <= h_rdata_d;
         m_request_q    <= m_request_d;
         slave_select_q <= slave_select_d;
         m_valid_q      <= m_valid_d;
         m_rw_q         <= m_rw_d;
         m_sout_q       <= m_sout_d;
      end
   end

   assign h_ready      = h_ready_q;
   assign h_done       = h_done_q;
   assign h_error      = h_error_q;
   assign h_rdata      = h_rdata_q;
   assign m_request    = m_request_q;
   assign slave_select = slave_select_q;
   assign m_valid      = m_valid_q;
   assign m_rw         = m_rw_q;
   assign m_sout       = m_sout_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: two ports behind a small arbiter model; port 1
// carries the table-driven transactions, both ports share the contention case.
module tb_bus_master_port;

   localparam int SW = 3;
   localparam int AW = 12;
   localparam int DW = 8;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          h_start1, h_rw1, h_ready1, h_done1, h_error1;
   logic [SW-1:0] h_slave1;
   logic [AW-1:0] h_addr1;
   logic [DW-1:0] h_wdata1, h_rdata1;
   logic          m_request1, m_grant1, slave_select1, m_valid1, m_rw1, m_sout1, m_sin1, s_ready1;

   logic          h_start2, h_rw2, h_ready2, h_done2, h_error2;
   logic [SW-1:0] h_slave2;
   logic [AW-1:0] h_addr2;
   logic [DW-1:0] h_wdata2, h_rdata2;
   logic          m_request2, m_grant2, slave_select2, m_valid2, m_rw2, m_sout2, m_sin2, s_ready2;

   logic          arb_mode, man_g1;
   logic [1:0]    owner;

   bus_master_port u_m1 (
      .clk(clk), .reset(reset), .h_start(h_start1), .h_rw(h_rw1), .h_slave(h_slave1),
      .h_addr(h_addr1), .h_wdata(h_wdata1), .h_ready(h_ready1), .h_done(h_done1),
      .h_error(h_error1), .h_rdata(h_rdata1), .m_request(m_request1), .m_grant(m_grant1),
      .slave_select(slave_select1), .m_valid(m_valid1), .m_rw(m_rw1), .m_sout(m_sout1),
      .m_sin(m_sin1), .s_ready(s_ready1)
   );

   bus_master_port u_m2 (
      .clk(clk), .reset(reset), .h_start(h_start2), .h_rw(h_rw2), .h_slave(h_slave2),
      .h_addr(h_addr2), .h_wdata(h_wdata2), .h_ready(h_ready2), .h_done(h_done2),
      .h_error(h_error2), .h_rdata(h_rdata2), .m_request(m_request2), .m_grant(m_grant2),
      .slave_select(slave_select2), .m_valid(m_valid2), .m_rw(m_rw2), .m_sout(m_sout2),
      .m_sin(m_sin2), .s_ready(s_ready2)
   );

   // Arbiter model: fixed priority m1 > m2, grant held until the owner drops request.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= 2'd0;
      end else if (owner == 2'd0) begin
         if (m_request1)      owner <= 2'd1;
         else if (m_request2) owner <= 2'd2;
      end else if ((owner == 2'd1 && !m_request1) || (owner == 2'd2 && !m_request2)) begin
         owner <= 2'd0;
      end
   end

   assign m_grant1 = arb_mode ? (owner == 2'd1) : man_g1;
   assign m_grant2 = arb_mode && (owner == 2'd2);

   typedef struct {
      logic          rw;
      logic [SW-1:0] slave;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;    // data the slave returns on m_sin
      int            gdly;     // cycles from m_request seen to grant
      int            srdy;     // WAIT cycle carrying s_ready, -1 = never
      int            drop;     // cycle offset after grant where grant drops, 0 = never
      int            rst;      // cycle offset after grant where reset hits, 0 = never
      logic          poke;     // pulse h_start while busy
      logic          exp_err;  // expected h_error
   } vec_t;

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
   } exp_t;

   localparam int NV = 11;
   vec_t          vecs [NV];
   exp_t          sb [$];
   int            n_cmp = 0;
   int            n_fail = 0;
   logic [DW-1:0] last_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every h_done pops one expected result.
   always @(negedge clk) begin : mon
      exp_t e;
      if (h_done1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got h_done=1, expected 0");
         end else begin
            e = sb.pop_front();
            chk("h_error", 32'(h_error1), 32'(e.err));
            chk("h_rdata", 32'(h_rdata1), 32'(e.rdata));
         end
      end
   end

   task automatic run_txn(input vec_t v);
      int               n, k_sr, rd0, done_off, seen;
      logic [SW-1:0]    sel_got;
      logic [AW+DW-1:0] sout_got, sout_exp;
      logic [3:0]       done_bus;
      logic [DW-1:0]    tmp;
      logic             vbad;
      exp_t             e;

      n    = AW + (v.rw ? DW : 0);
      k_sr = SW + 1 + n + v.srdy;
      rd0  = k_sr + 1;
      if (v.drop > 0)     done_off = v.drop + 1;
      else if (v.srdy < 0) done_off = SW + 1 + n + TO;
      else if (v.rw)      done_off = k_sr + 1;
      else                done_off = k_sr + 1 + DW;
      e.err   = v.exp_err;
      e.rdata = (!v.rw && !v.exp_err) ? v.rdata : last_rd;
      sout_exp = v.rw ? {v.wdata, v.addr} : {{DW{1'b0}}, v.addr};

      @(negedge clk);
      chk("ready_idle", 32'(h_ready1), 32'd1);
      h_start1 = 1'b1; h_rw1 = v.rw; h_slave1 = v.slave; h_addr1 = v.addr; h_wdata1 = v.wdata;
      sb.push_back(e);
      @(negedge clk);
      h_start1 = 1'b0;
      chk("req_rw", 32'({m_request1, h_ready1, m_rw1}), 32'({1'b1, 1'b0, v.rw}));
      repeat (v.gdly) @(negedge clk);
      man_g1 = 1'b1;

      sel_got = '0; sout_got = '0; vbad = 1'b0; seen = 0; done_bus = '1;
      for (int off = 1; off <= done_off; off++) begin
         @(negedge clk);
         if (off <= SW) sel_got = sel_got | (SW'(slave_select1) << (off - 1));
         if (off > SW && off <= SW + n) begin
            sout_got = sout_got | ((AW+DW)'(m_sout1) << (off - SW - 1));
            if (!m_valid1) vbad = 1'b1;
         end
         if (h_done1 && seen == 0) seen = off;
         if (off == done_off) done_bus = {m_request1, m_valid1, slave_select1, m_sout1};
         if (v.rst > 0 && off == v.rst) begin
            reset = 1'b1; man_g1 = 1'b0; s_ready1 = 1'b0; m_sin1 = 1'b0;
            @(negedge clk);
            chk("reset_outs", 32'({h_ready1, h_done1, h_error1, h_rdata1, m_request1,
                                   slave_select1, m_valid1, m_rw1, m_sout1}), 32'h8000);
            reset = 1'b0;
            sb.delete();
            last_rd = '0;
            repeat (3) @(negedge clk);
            chk("reset_idle", 32'({h_ready1, h_done1}), 32'b10);
            return;
         end
         man_g1   = !(v.drop > 0 && off >= v.drop) && (off < done_off);
         s_ready1 = (v.srdy >= 0 && off == k_sr);
         tmp      = v.rdata >> (off - rd0);
         m_sin1   = (off >= rd0 && off < rd0 + DW) ? tmp[0] : 1'b0;
         h_start1 = v.poke && (off == 2);
         h_addr1  = (v.poke && off == 2) ? ~v.addr : v.addr;
      end

      chk("done_latency", 32'(seen), 32'(done_off));
      chk("done_bus", 32'(done_bus), 32'd0);
      if (v.drop == 0) begin
         chk("sel_bits", 32'(sel_got), 32'(v.slave));
         chk("sout_bits", 32'(sout_got), 32'(sout_exp));
         chk("valid_window", 32'(vbad), 32'd0);
      end
      @(negedge clk);
      chk("ready_after", 32'({h_ready1, h_done1, m_request1}), 32'b100);
      last_rd = e.rdata;
   endtask

   initial begin
      int   g1t, s1t, d1t, g2t, s2t, d2t;
      logic e2err;
      exp_t e;

      reset = 1'b1; arb_mode = 1'b0; man_g1 = 1'b0; last_rd = '0;
      h_start1 = 1'b0; h_rw1 = 1'b0; h_slave1 = '0; h_addr1 = '0; h_wdata1 = '0;
      m_sin1 = 1'b0; s_ready1 = 1'b0;
      h_start2 = 1'b0; h_rw2 = 1'b0; h_slave2 = '0; h_addr2 = '0; h_wdata2 = '0;
      m_sin2 = 1'b0; s_ready2 = 1'b0;

      //          rw    slave   addr     wdata  rdata  gd srdy drop rst poke  err
      vecs[0]  = '{1'b1, 3'b101, 12'h0A5, 8'h3C, 8'h00, 2,  0,  0,   0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 3'b010, 12'h123, 8'h00, 8'h96, 1,  4,  0,   0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 3'b100, 12'hF0F, 8'h55, 8'h00, 0, -1,  0,   0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 3'b011, 12'h3C3, 8'hA7, 8'h00, 1,  0,  8,   0, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 3'b001, 12'h456, 8'h00, 8'hEE, 3, -1,  0,   0, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 3'b110, 12'h9E7, 8'h00, 8'h5A, 0, 14,  0,   0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 3'b111, 12'hFFF, 8'hFF, 8'h00, 1, 14,  0,   0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 3'b101, 12'h222, 8'h00, 8'h33, 1,  0, 19,   0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 3'b010, 12'h001, 8'h80, 8'h00, 2,  0,  1,   0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 3'b110, 12'h7E1, 8'h00, 8'hC3, 1,  0,  0,  20, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 3'b001, 12'hABC, 8'h00, 8'h81, 2,  2,  0,   0, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      chk("reset_state", 32'({h_ready1, h_done1, h_error1, h_rdata1, m_request1,
                              slave_select1, m_valid1, m_rw1, m_sout1}), 32'h8000);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_txn(vecs[i]);

      // Contention: both ports start together and must serialise.
      arb_mode = 1'b1; s_ready1 = 1'b1; s_ready2 = 1'b1;
      @(negedge clk);
      h_start1 = 1'b1; h_rw1 = 1'b1; h_slave1 = 3'b011; h_addr1 = 12'h555; h_wdata1 = 8'hA1;
      h_start2 = 1'b1; h_rw2 = 1'b1; h_slave2 = 3'b101; h_addr2 = 12'h2AA; h_wdata2 = 8'h5E;
      e.err = 1'b0; e.rdata = last_rd;
      sb.push_back(e);
      @(negedge clk);
      h_start1 = 1'b0; h_start2 = 1'b0;
      g1t = -1; s1t = -1; d1t = -1; g2t = -1; s2t = -1; d2t = -1; e2err = 1'b1;
      for (int t = 1; t <= 150; t++) begin
         @(negedge clk);
         if (m_grant1 && g1t < 0)      g1t = t;
         if (slave_select1 && s1t < 0) s1t = t;
         if (h_done1 && d1t < 0)       d1t = t;
         if (m_grant2 && g2t < 0)      g2t = t;
         if (slave_select2 && s2t < 0) s2t = t;
         if (h_done2 && d2t < 0) begin
            d2t   = t;
            e2err = h_error2;
         end
         if (d2t >= 0) break;
      end
      chk("c_sel1_after_grant", 32'(s1t - g1t), 32'd1);
      chk("c_sel2_after_grant", 32'(s2t - g2t), 32'd1);
      chk("c_serialised", 32'(g2t > d1t && d1t > 0), 32'd1);
      chk("c_done2", 32'({d2t >= 0, e2err}), 32'b10);
      arb_mode = 1'b0; s_ready1 = 1'b0; s_ready2 = 1'b0;
      repeat (3) @(negedge clk);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
